// File: rtl/sound_player.sv
// -----------------------------------------------------------------------------
// sound_player
//
// Sequenced square-wave sound generator. A one-cycle play_sound event selects a
// short melody (sound_code 1..3) that is played as fixed-length square-wave
// notes, each followed by a silent gap. Code 0 aborts playback, codes 4..7 are
// ignored. A new valid code while playing restarts from the first note.
//
// Parameters:
//   CLK_FREQ    clock frequency in Hz
//   NOTE_MS     tone length of every note in ms
//   GAP_MS      silent gap after every note in ms
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   sound_code  melody select, sampled only while play_sound is high
//   play_sound  trigger, each high cycle is one event
//   audio_pwm   square-wave audio output
//   audio_sd    amplifier enable (1 = on), identical to busy
//   busy        high from the first tone through the last gap
// -----------------------------------------------------------------------------
module sound_player #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int NOTE_MS  = 80,
  parameter int GAP_MS   = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic       busy
);

  localparam int NOTE_CYCLES = CLK_FREQ / 1000 * NOTE_MS;
  localparam int GAP_CYCLES  = CLK_FREQ / 1000 * GAP_MS;

  localparam int HALF_C5 = CLK_FREQ / (2 * 523);
  localparam int HALF_E5 = CLK_FREQ / (2 * 659);
  localparam int HALF_G5 = CLK_FREQ / (2 * 784);
  localparam int HALF_C6 = CLK_FREQ / (2 * 1047);

  // C5 is the lowest note, so it has the longest half-period.
  localparam int MAX_DUR = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_DUR > HALF_C5) ? MAX_DUR : HALF_C5;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_C5_W = CNT_W'(HALF_C5);
  localparam logic [CNT_W-1:0] HALF_E5_W = CNT_W'(HALF_E5);
  localparam logic [CNT_W-1:0] HALF_G5_W = CNT_W'(HALF_G5);
  localparam logic [CNT_W-1:0] HALF_C6_W = CNT_W'(HALF_C6);

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP
  } state_t;

  state_t           r_state;
  logic [1:0]       r_code;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_durCnt;
  logic [CNT_W-1:0] r_toneCnt;
  logic             r_pwm;
  logic             r_busy;

  logic             w_start;
  logic             w_stop;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_halfLast;
  logic [1:0]       w_lastIdx;

  // Only codes 1..3 start a melody; code 0 stops; 4..7 fall through untouched.
  assign w_start = play_sound && !sound_code[2] && (sound_code[1:0] != 2'b00);
  assign w_stop  = play_sound && (sound_code == 3'd0);

  // Melody table: half-period of the current note and index of the final note.
  always_comb begin
    w_half    = HALF_G5_W;
    w_lastIdx = 2'd0;
    case (r_code)
      2'd2: begin
        w_lastIdx = 2'd1;
        w_half    = (r_idx == 2'd0) ? HALF_E5_W : HALF_C5_W;
      end
      2'd3: begin
        w_lastIdx = 2'd3;
        case (r_idx)
          2'd0:    w_half = HALF_C5_W;
          2'd1:    w_half = HALF_E5_W;
          2'd2:    w_half = HALF_G5_W;
          default: w_half = HALF_C6_W;
        endcase
      end
      default: begin
        w_lastIdx = 2'd0;
        w_half    = HALF_G5_W;
      end
    endcase
  end

  assign w_halfLast = w_half - CNT_W'(1);

  // Playback FSM. Stop and (re)start triggers override whatever state we are
  // in, which also gives a trigger on the final-gap cycle priority over the
  // return to IDLE, so busy stays high across back-to-back melodies.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_code    <= 2'd0;
      r_idx     <= 2'd0;
      r_durCnt  <= '0;
      r_toneCnt <= '0;
      r_pwm     <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_stop) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_durCnt  <= '0;
      r_toneCnt <= '0;
      r_pwm     <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_start) begin
      r_state   <= TONE;
      r_code    <= sound_code[1:0];
      r_idx     <= 2'd0;
      r_durCnt  <= '0;
      r_toneCnt <= '0;
      r_pwm     <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_pwm  <= 1'b0;
          r_busy <= 1'b0;
        end
        TONE: begin
          if (r_durCnt == NOTE_LAST) begin
            r_state   <= GAP;
            r_durCnt  <= '0;
            r_toneCnt <= '0;
            r_pwm     <= 1'b0;
          end else begin
            r_durCnt <= r_durCnt + CNT_W'(1);
            if (r_toneCnt == w_halfLast) begin
              r_toneCnt <= '0;
              r_pwm     <= ~r_pwm;
            end else begin
              r_toneCnt <= r_toneCnt + CNT_W'(1);
            end
          end
        end
        GAP: begin
          r_pwm <= 1'b0;
          if (r_durCnt == GAP_LAST) begin
            r_durCnt <= '0;
            if (r_idx == w_lastIdx) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= TONE;
              r_idx     <= r_idx + 2'd1;
              r_toneCnt <= '0;
            end
          end else begin
            r_durCnt <= r_durCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_pwm   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign audio_pwm = r_pwm;
  assign busy      = r_busy;
  assign audio_sd  = r_busy;

endmodule

// File: tb/tb_sound_player.sv
// -----------------------------------------------------------------------------
// tb_sound_player
//
// Scoreboard bench for sound_player with CLK_FREQ=1 MHz, NOTE_MS=2, GAP_MS=1
// (2000-cycle notes, 1000-cycle gaps). Each stimulus pushes the expected output
// changes (cycle, busy, pwm) into a queue; a monitor pops one entry for every
// change it observes on busy/audio_pwm and compares.
// -----------------------------------------------------------------------------
module tb_sound_player;

  localparam int NOTE_CYCLES = 2000;
  localparam int GAP_CYCLES  = 1000;
  localparam int NOTE_PERIOD = NOTE_CYCLES + GAP_CYCLES;
  localparam int NEVER       = 32'h7fff_ffff;

  typedef struct {
    int cyc;
    bit busy;
    bit pwm;
  } evt_t;

  logic       clk;
  logic       rstn;
  logic [2:0] sound_code;
  logic       play_sound;
  logic       audio_pwm;
  logic       audio_sd;
  logic       busy;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  evt_t expQ[$];
  logic prevBusy = 1'b0;
  logic prevPwm  = 1'b0;

  sound_player #(
    .CLK_FREQ(1_000_000),
    .NOTE_MS (2),
    .GAP_MS  (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sound_code(sound_code),
    .play_sound(play_sound),
    .audio_pwm (audio_pwm),
    .audio_sd  (audio_sd),
    .busy      (busy)
  );

  // Free-running clock and an edge counter used as the time base.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic pushEvt(input int c, input bit b, input bit p);
    evt_t e;
    e.cyc  = c;
    e.busy = b;
    e.pwm  = p;
    expQ.push_back(e);
  endtask

  // Expected output changes for a melody whose first busy cycle is t0, stopping
  // before cycle 'cutoff' (where an interrupting event takes over). Reports the
  // pwm level and busy state the melody would have at the cutoff.
  task automatic expectMelody(input int t0, input int code, input int cutoff,
                              input bit busyHigh, output bit pwmAtCut, output bit busyAtCut);
    int halves[4];
    int n;
    int s;
    bit lvl;
    lvl       = 1'b0;
    pwmAtCut  = 1'b0;
    busyAtCut = 1'b1;
    case (code)
      1:       begin n = 1; halves = '{637, 0, 0, 0};       end
      2:       begin n = 2; halves = '{758, 956, 0, 0};     end
      default: begin n = 4; halves = '{956, 758, 637, 477}; end
    endcase
    if (!busyHigh) pushEvt(t0, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      s = t0 + k * NOTE_PERIOD;
      for (int m = halves[k]; m < NOTE_CYCLES; m += halves[k]) begin
        if (s + m >= cutoff) begin
          pwmAtCut = lvl;
          return;
        end
        lvl = ~lvl;
        pushEvt(s + m, 1'b1, lvl);
      end
      if (lvl) begin
        if (s + NOTE_CYCLES >= cutoff) begin
          pwmAtCut = lvl;
          return;
        end
        lvl = 1'b0;
        pushEvt(s + NOTE_CYCLES, 1'b1, 1'b0);
      end
    end
    if (t0 + n * NOTE_PERIOD < cutoff) begin
      pushEvt(t0 + n * NOTE_PERIOD, 1'b0, 1'b0);
      busyAtCut = 1'b0;
    end
  endtask

  // Called at a falling edge: the trigger is sampled at the next rising edge.
  task automatic applyStimulus(input logic [2:0] code);
    play_sound = 1'b1;
    sound_code = code;
    @(negedge clk);
    play_sound = 1'b0;
    sound_code = 3'd0;
  endtask

  // Monitor: checks invariants each cycle and matches every output change
  // against the head of the expected-event queue.
  always @(negedge clk) begin
    evt_t e;
    checkOutput("audioSdEqualsBusy", int'(audio_sd), int'(busy));
    checkOutput("pwmLowWhileIdle", int'(audio_pwm & ~busy), 0);
    if (busy !== prevBusy || audio_pwm !== prevPwm) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpectedChange: got cycle %0d busy=%0b pwm=%0b, expected no change",
                 cyc, busy, audio_pwm);
      end else begin
        e = expQ.pop_front();
        checkOutput("eventCycle", cyc, e.cyc);
        checkOutput("eventBusy", int'(busy), int'(e.busy));
        checkOutput("eventPwm", int'(audio_pwm), int'(e.pwm));
      end
    end
    prevBusy <= busy;
    prevPwm  <= audio_pwm;
  end

  initial begin
    int t1;
    int t2;
    bit pwmCut;
    bit busyCut;

    rstn       = 1'b1;
    play_sound = 1'b0;
    sound_code = 3'd0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetPwm", int'(audio_pwm), 0);
    checkOutput("resetSd", int'(audio_sd), 0);
    checkOutput("resetBusy", int'(busy), 0);
    rstn = 1'b1;
    repeat (100) @(negedge clk);

    $display("[TB] single note, code 1");
    t1 = cyc + 1;
    expectMelody(t1, 1, NEVER, 1'b0, pwmCut, busyCut);
    applyStimulus(3'd1);
    repeat (NOTE_PERIOD + 20) @(negedge clk);

    $display("[TB] four notes, code 3");
    t1 = cyc + 1;
    expectMelody(t1, 3, NEVER, 1'b0, pwmCut, busyCut);
    applyStimulus(3'd3);
    repeat (4 * NOTE_PERIOD + 20) @(negedge clk);

    $display("[TB] code 3 preempted by code 2 after 4500 cycles");
    t1 = cyc + 1;
    t2 = t1 + 4500;
    expectMelody(t1, 3, t2, 1'b0, pwmCut, busyCut);
    if (pwmCut) pushEvt(t2, 1'b1, 1'b0);
    expectMelody(t2, 2, NEVER, 1'b1, pwmCut, busyCut);
    applyStimulus(3'd3);
    repeat (4499) @(negedge clk);
    applyStimulus(3'd2);
    repeat (2 * NOTE_PERIOD + 20) @(negedge clk);

    $display("[TB] code 2 stopped by code 0 after 500 cycles");
    t1 = cyc + 1;
    expectMelody(t1, 2, t1 + 500, 1'b0, pwmCut, busyCut);
    if (busyCut) pushEvt(t1 + 500, 1'b0, 1'b0);
    applyStimulus(3'd2);
    repeat (499) @(negedge clk);
    applyStimulus(3'd0);
    repeat (50) @(negedge clk);

    $display("[TB] ignored codes 5 (idle) and 6 (mid-melody)");
    applyStimulus(3'd5);
    repeat (50) @(negedge clk);
    t1 = cyc + 1;
    expectMelody(t1, 1, NEVER, 1'b0, pwmCut, busyCut);
    applyStimulus(3'd1);
    repeat (999) @(negedge clk);
    applyStimulus(3'd6);
    repeat (2 * NOTE_CYCLES + 20) @(negedge clk);

    $display("[TB] retrigger on final gap cycle");
    t1 = cyc + 1;
    t2 = t1 + NOTE_PERIOD;
    expectMelody(t1, 1, t2, 1'b0, pwmCut, busyCut);
    expectMelody(t2, 1, NEVER, 1'b1, pwmCut, busyCut);
    applyStimulus(3'd1);
    repeat (NOTE_PERIOD - 1) @(negedge clk);
    applyStimulus(3'd1);
    repeat (NOTE_PERIOD + 20) @(negedge clk);

    $display("[TB] asynchronous reset while pwm high");
    t1 = cyc + 1;
    expectMelody(t1, 1, t1 + 701, 1'b0, pwmCut, busyCut);
    pushEvt(t1 + 701, 1'b0, 1'b0);
    applyStimulus(3'd1);
    repeat (700) @(negedge clk);
    checkOutput("pwmHighBeforeReset", int'(audio_pwm), 1);
    #1 rstn = 1'b0;
    #1;
    checkOutput("asyncResetPwm", int'(audio_pwm), 0);
    checkOutput("asyncResetSd", int'(audio_sd), 0);
    checkOutput("asyncResetBusy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);

    checkOutput("pendingEvents", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
